neuron_accumulator: RTL and testbench
=====================================

Name: neuron_accumulator

Overview:
- Per-neuron stage directly downstream of the axon/weight integrator.
- Each tick it consumes one signed weight contribution per axon, NUM_AXONS in total, and accumulates them into a saturating membrane potential.
- After the last axon it applies the leak, compares against the thresholds, emits a one-cycle spike and applies the reset rule.
- Potential persists across ticks. The spike output feeds the core's spike router.

Parameters:
NUM_AXONS, 256, contributions accumulated per tick
LEAK_WIDTH, 9, width of signed leak value
WEIGHT_WIDTH, 9, width of signed contribution from integrator
THRESHOLD_WIDTH, 9, width of unsigned positive/negative thresholds
POTENTIAL_WIDTH, 9, width of signed membrane potential
NUM_RESET_MODES, 2, reset modes supported (0 = absolute, 1 = linear)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-high reset
tick_i  input  1  start-of-tick pulse; honoured only in IDLE
contrib_valid_i  input  1  contrib_i valid this cycle
contrib_i  input  WEIGHT_WIDTH  signed contribution (0 when axon/synapse inactive)
leak_i  input  LEAK_WIDTH  signed leak added once per tick
pos_threshold_i  input  THRESHOLD_WIDTH  unsigned firing threshold
neg_threshold_i  input  THRESHOLD_WIDTH  unsigned magnitude of negative floor
reset_potential_i  input  POTENTIAL_WIDTH  signed value loaded on fire, mode 0
reset_mode_i  input  max(1,$clog2(NUM_RESET_MODES))  reset mode select
busy_o  output  1  high in any state other than IDLE
spike_o  output  1  one-cycle fire pulse
done_o  output  1  one-cycle tick-complete pulse
membrane_potential_o  output  POTENTIAL_WIDTH  current signed potential (registered)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset state: state=IDLE, potential=0, axon counter=0, spike_o=0, done_o=0, busy_o=0.
- rst_i mid-tick aborts the tick and returns to the reset state with no spike and no done.
- States: IDLE, INTEGRATE, LEAK, FIRE.
- IDLE:
  - tick_i=1 moves to INTEGRATE and clears the counter.
  - contrib_valid_i is ignored in IDLE.
- INTEGRATE:
  - Each cycle with contrib_valid_i=1 sets potential = sat(potential + sext(contrib_i)) and increments the counter.
  - The valid beat with counter==NUM_AXONS-1 moves to LEAK.
  - Cycles without valid hold all state. tick_i is ignored.
- LEAK: potential = sat(potential + sext(leak_i)), then move to FIRE.
- FIRE (thresholds zero-extended, compared in signed POTENTIAL_WIDTH+2 bits):
  - If potential >= pos_threshold_i: spike.
    - Mode 0: potential = reset_potential_i.
    - Mode 1: potential = sat(potential - pos_threshold_i).
  - Else if potential < -neg_threshold_i: potential = -neg_threshold_i, saturated to the minimum value. No spike.
  - Else: potential unchanged.
  - Always return to IDLE.
- Spike and done timing:
  - spike_o (when firing) and done_o are registered and high exactly one cycle, the cycle after FIRE.
  - That is the same cycle the state reads IDLE.
- Latency: last valid accepted at edge t gives LEAK during t+1, FIRE during t+2, spike_o/done_o high during t+3.
  - Minimum tick length is NUM_AXONS+3 cycles from tick_i.
- Saturation and widths:
  - sat() clamps to [-2^(POTENTIAL_WIDTH-1), 2^(POTENTIAL_WIDTH-1)-1]; defaults give -256..255.
  - All intermediate sums are computed at POTENTIAL_WIDTH+2 bits, then clamped. No wrap-around is ever allowed.
- Sampling: leak_i, thresholds, reset_potential_i and reset_mode_i are sampled in the cycle they are used. They must be stable from tick_i until done_o.
- Reserved modes: reset_mode_i values >= NUM_RESET_MODES behave as mode 0.
- Counter width: $clog2(NUM_AXONS)+1. The counter never exceeds NUM_AXONS-1 while in INTEGRATE.
- Back-to-back ticks: tick_i in the done_o cycle is accepted, because the state is IDLE.

Test Plan:
1. NUM_AXONS=4, potential 0, contribs 10,20,30,40, leak -5, pos_th 100, mode 0, reset_pot 0 -> potential 95, spike_o=0, done_o pulses 1 cycle at t+3.
2. Same setup, contribs 50,50,50,50, leak 0, pos_th 100, mode 1 -> sum 200 ≥ 100 -> spike_o=1 for one cycle, potential 100; next identical tick -> 300 clamps to 255 -> spike, potential 155.
3. Saturation: contribs -200,-200,0,0, leak 0, neg_th 50 -> sum clamps at -256 (never wraps positive) -> floor applied, potential -50, no spike.
4. Gapped valids: 4 valids spread over 10 cycles with contrib_valid_i low between them, plus a tick_i mid-INTEGRATE -> extra tick ignored, done_o exactly once, 3 cycles after the 4th valid.
5. rst_i asserted during LEAK with the potential heading to a spike -> next cycle potential 0, IDLE, no spike_o/done_o; a subsequent tick operates normally.
6. Default NUM_AXONS=256, all contribs +1, leak 0, pos_th 255, mode 0, reset_pot 7 -> 256 saturates to 255 ≥ 255 -> spike_o=1, potential 7, busy_o high for exactly 259 cycles.

Source files
------------

// File: rtl/neuron_accumulator.sv
// Per-neuron membrane potential accumulator.
//
// Each tick it accepts NUM_AXONS signed weight contributions and adds them into
// a saturating membrane potential. It then adds the leak, checks the potential
// against the firing threshold and the negative floor, and applies the reset
// rule. The potential is kept from one tick to the next.
//
// Ports:
//   clk_i                 clock, all state on the rising edge
//   rst_i                 synchronous active-high reset
//   tick_i                start-of-tick pulse, honoured only in IDLE
//   contrib_valid_i       contrib_i is valid this cycle
//   contrib_i             signed contribution from the integrator
//   leak_i                signed leak, added once per tick
//   pos_threshold_i       unsigned firing threshold
//   neg_threshold_i       unsigned magnitude of the negative floor
//   reset_potential_i     potential loaded on fire in mode 0
//   reset_mode_i          0 = absolute, 1 = linear, reserved codes act as 0
//   busy_o                high whenever the FSM is not idle
//   spike_o               one-cycle fire pulse
//   done_o                one-cycle tick-complete pulse
//   membrane_potential_o  registered signed potential
module neuron_accumulator #(
  parameter int unsigned NUM_AXONS       = 256,
  parameter int unsigned LEAK_WIDTH      = 9,
  parameter int unsigned WEIGHT_WIDTH    = 9,
  parameter int unsigned THRESHOLD_WIDTH = 9,
  parameter int unsigned POTENTIAL_WIDTH = 9,
  parameter int unsigned NUM_RESET_MODES = 2,
  localparam int unsigned ModeWidth = (NUM_RESET_MODES > 1) ? $clog2(NUM_RESET_MODES) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              tick_i,
  input  logic                              contrib_valid_i,
  input  logic signed [WEIGHT_WIDTH-1:0]    contrib_i,
  input  logic signed [LEAK_WIDTH-1:0]      leak_i,
  input  logic        [THRESHOLD_WIDTH-1:0] pos_threshold_i,
  input  logic        [THRESHOLD_WIDTH-1:0] neg_threshold_i,
  input  logic signed [POTENTIAL_WIDTH-1:0] reset_potential_i,
  input  logic        [ModeWidth-1:0]       reset_mode_i,
  output logic                              busy_o,
  output logic                              spike_o,
  output logic                              done_o,
  output logic signed [POTENTIAL_WIDTH-1:0] membrane_potential_o
);

  // Two guard bits so that any single add/subtract is exact before clamping.
  localparam int unsigned SumWidth = POTENTIAL_WIDTH + 2;
  localparam int unsigned CntWidth = $clog2(NUM_AXONS) + 1;

  localparam logic signed [SumWidth-1:0] PotMax = {3'b000, {(POTENTIAL_WIDTH - 1){1'b1}}};
  localparam logic signed [SumWidth-1:0] PotMin = {3'b111, {(POTENTIAL_WIDTH - 1){1'b0}}};
  localparam logic [CntWidth-1:0]        LastAxon = CntWidth'(NUM_AXONS - 1);

  typedef enum logic [1:0] {StIdle, StIntegrate, StLeak, StFire} state_e;

  state_e                              state_q, state_d;
  logic signed [POTENTIAL_WIDTH-1:0]   potential_q, potential_d;
  logic        [CntWidth-1:0]          cnt_q, cnt_d;
  logic                                spike_q, spike_d;
  logic                                done_q, done_d;

  logic signed [SumWidth-1:0] pot_ext, contrib_ext, leak_ext;
  logic signed [SumWidth-1:0] pos_th_ext, neg_th_ext, neg_floor;
  logic                       linear_mode;

  function automatic logic signed [POTENTIAL_WIDTH-1:0] sat(input logic signed [SumWidth-1:0] v);
    if (v > PotMax) begin
      return PotMax[POTENTIAL_WIDTH-1:0];
    end else if (v < PotMin) begin
      return PotMin[POTENTIAL_WIDTH-1:0];
    end else begin
      return v[POTENTIAL_WIDTH-1:0];
    end
  endfunction

  always_comb begin
    pot_ext     = SumWidth'(potential_q);
    contrib_ext = SumWidth'(contrib_i);
    leak_ext    = SumWidth'(leak_i);
    // Thresholds are unsigned, so these casts zero-extend.
    pos_th_ext  = SumWidth'(pos_threshold_i);
    neg_th_ext  = SumWidth'(neg_threshold_i);
    neg_floor   = '0 - neg_th_ext;
    // Reserved mode codes fall back to absolute reset.
    linear_mode = (NUM_RESET_MODES > 1) && (reset_mode_i == ModeWidth'(1));
  end

  always_comb begin
    state_d     = state_q;
    potential_d = potential_q;
    cnt_d       = cnt_q;
    spike_d     = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick_i) begin
          state_d = StIntegrate;
          cnt_d   = '0;
        end
      end
      StIntegrate: begin
        if (contrib_valid_i) begin
          potential_d = sat(pot_ext + contrib_ext);
          cnt_d       = cnt_q + CntWidth'(1);
          if (cnt_q == LastAxon) begin
            state_d = StLeak;
          end
        end
      end
      StLeak: begin
        potential_d = sat(pot_ext + leak_ext);
        state_d     = StFire;
      end
      StFire: begin
        if (pot_ext >= pos_th_ext) begin
          spike_d     = 1'b1;
          potential_d = linear_mode ? sat(pot_ext - pos_th_ext) : reset_potential_i;
        end else if (pot_ext < neg_floor) begin
          potential_d = sat(neg_floor);
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      potential_q <= '0;
      cnt_q       <= '0;
      spike_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      potential_q <= potential_d;
      cnt_q       <= cnt_d;
      spike_q     <= spike_d;
      done_q      <= done_d;
    end
  end

  assign busy_o               = (state_q != StIdle);
  assign spike_o              = spike_q;
  assign done_o               = done_q;
  assign membrane_potential_o = potential_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: a 4-axon instance for the short
// scenarios and a default 256-axon instance for the full-length tick.
module tb_neuron_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic signed [8:0] leak = '0;
  logic        [8:0] pos_th = '0;
  logic        [8:0] neg_th = '0;
  logic signed [8:0] reset_pot = '0;
  logic        [0:0] reset_mode = '0;

  logic              tick4 = 1'b0, valid4 = 1'b0;
  logic signed [8:0] contrib4 = '0;
  logic              busy4, spike4, done4;
  logic signed [8:0] pot4;

  logic              tick256 = 1'b0, valid256 = 1'b0;
  logic signed [8:0] contrib256 = '0;
  logic              busy256, spike256, done256;
  logic signed [8:0] pot256;

  int errors = 0;
  int checks = 0;

  neuron_accumulator #(.NUM_AXONS(4)) dut4 (
    .clk_i                (clk),
    .rst_i                (rst),
    .tick_i               (tick4),
    .contrib_valid_i      (valid4),
    .contrib_i            (contrib4),
    .leak_i               (leak),
    .pos_threshold_i      (pos_th),
    .neg_threshold_i      (neg_th),
    .reset_potential_i    (reset_pot),
    .reset_mode_i         (reset_mode),
    .busy_o               (busy4),
    .spike_o              (spike4),
    .done_o               (done4),
    .membrane_potential_o (pot4)
  );

  neuron_accumulator dut256 (
    .clk_i                (clk),
    .rst_i                (rst),
    .tick_i               (tick256),
    .contrib_valid_i      (valid256),
    .contrib_i            (contrib256),
    .leak_i               (leak),
    .pos_threshold_i      (pos_th),
    .neg_threshold_i      (neg_th),
    .reset_potential_i    (reset_pot),
    .reset_mode_i         (reset_mode),
    .busy_o               (busy256),
    .spike_o              (spike256),
    .done_o               (done256),
    .membrane_potential_o (pot256)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Tick followed by four back-to-back valid beats; returns in the LEAK cycle.
  task automatic tick4_contribs(input int c0, input int c1, input int c2, input int c3);
    int c [4];
    c = '{c0, c1, c2, c3};
    tick4 = 1'b1;
    step();
    tick4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid4   = 1'b1;
      contrib4 = 9'(c[i]);
      step();
    end
    valid4   = 1'b0;
    contrib4 = '0;
  endtask

  // Entered in the LEAK cycle; walks FIRE, the done cycle and the one after.
  task automatic finish_tick(input string tag, input int exp_spike, input int exp_pot);
    chk({tag, "_leak_busy"}, busy4, 1);
    chk({tag, "_leak_done"}, done4, 0);
    step();
    chk({tag, "_fire_done"}, done4, 0);
    chk({tag, "_fire_spike"}, spike4, 0);
    step();
    chk({tag, "_done"}, done4, 1);
    chk({tag, "_spike"}, spike4, exp_spike);
    chk({tag, "_pot"}, pot4, exp_pot);
    chk({tag, "_idle"}, busy4, 0);
    step();
    chk({tag, "_done_clr"}, done4, 0);
    chk({tag, "_spike_clr"}, spike4, 0);
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, spike_at_done, pot_at_done;

    // Reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_pot", pot4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_spike", spike4, 0);
    chk("rst_done", done4, 0);

    // 1: 10+20+30+40 = 100, leak -5 -> 95 < 100, no spike.
    leak = -9'sd5; pos_th = 9'd100; neg_th = 9'd200; reset_mode = 1'b0; reset_pot = '0;
    tick4_contribs(10, 20, 30, 40);
    finish_tick("t1", 0, 95);

    // 2: linear reset. From 0: 200 -> spike, 100. Then 100+200 clamps to 255 -> 155.
    rst = 1'b1;
    step();
    rst = 1'b0;
    leak = '0; reset_mode = 1'b1;
    tick4_contribs(50, 50, 50, 50);
    finish_tick("t2a", 1, 100);
    tick4_contribs(50, 50, 50, 50);
    finish_tick("t2b", 1, 155);

    // 3: negative saturation then floor at -neg_th.
    rst = 1'b1;
    step();
    rst = 1'b0;
    reset_mode = 1'b0; neg_th = 9'd50;
    tick4 = 1'b1;
    step();
    tick4 = 1'b0;
    valid4 = 1'b1; contrib4 = -9'sd200;
    step();
    chk("t3_first", pot4, -200);
    step();
    chk("t3_clamp", pot4, -256);
    contrib4 = '0;
    step();
    step();
    valid4 = 1'b0;
    chk("t3_hold_min", pot4, -256);
    finish_tick("t3", 0, -50);

    // 4: valids at cycles 0,3,6,9 with a stray tick at cycle 1; start -50, +10 each.
    tick4 = 1'b1;
    step();
    tick4 = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      valid4   = (cyc % 3 == 0);
      contrib4 = 9'sd10;
      tick4    = (cyc == 1);
      step();
      if (cyc == 2) chk("t4_gap_hold", pot4, -40);
      if (cyc == 4) chk("t4_busy_mid", busy4, 1);
      if (cyc == 8) chk("t4_no_early_done", done4, 0);
    end
    valid4 = 1'b0; tick4 = 1'b0; contrib4 = '0;
    finish_tick("t4", 0, -10);

    // 5: reset during LEAK with 200 >= 100 pending.
    rst = 1'b1;
    step();
    rst = 1'b0;
    tick4_contribs(50, 50, 50, 50);
    chk("t5_in_leak", busy4, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_pot", pot4, 0);
    chk("t5_busy", busy4, 0);
    chk("t5_spike", spike4, 0);
    chk("t5_done", done4, 0);
    step();
    chk("t5_spike_after", spike4, 0);
    chk("t5_done_after", done4, 0);
    leak = -9'sd5;
    tick4_contribs(10, 20, 30, 40);
    finish_tick("t5_next", 0, 95);

    // 6: 256 axons of +1 -> 255 >= 255 -> spike, reload 7. The integrator delivers its
    // first beat one cycle after tick acceptance: 1 gap + 256 + LEAK + FIRE = 259 busy.
    leak = '0; pos_th = 9'd255; reset_mode = 1'b0; reset_pot = 9'sd7;
    tick256 = 1'b1;
    step();
    tick256 = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; spike_at_done = 0; pot_at_done = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (busy256) busy_cnt++;
      if (done256) begin
        done_cnt++;
        done_at       = cyc;
        spike_at_done = int'(spike256);
        pot_at_done   = int'(pot256);
      end
      valid256   = (cyc >= 1) && (cyc <= 256);
      contrib256 = 9'sd1;
      step();
    end
    valid256 = 1'b0;
    chk("t6_busy_cycles", busy_cnt, 259);
    chk("t6_done_count", done_cnt, 1);
    chk("t6_done_cycle", done_at, 259);
    chk("t6_spike", spike_at_done, 1);
    chk("t6_pot", pot_at_done, 7);
    chk("t6_final_pot", pot256, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
